barrett_reduce_arbiter: RTL and testbench

Shares one barrett_reduce instance (mod L = 2^252 + 27742317777372353535851937790883648493) between NUM_REQ requesters, e.g. sign-S cores, key-expansion and verify datapaths. Requesters are granted round-robin, and each accepted 512-bit operand is sequenced through the reducer's level-enable/done protocol. A watchdog converts a hung reduction into an error response. mult_busy lets the owning top steer the shared 256x256 multiplier mux toward the reducer.

---
 rtl/barrett_reduce_arbiter_if.sv | 31 +++
 rtl/barrett_reduce_arbiter.sv | 130 +++++++++++++
 tb/tb_barrett_reduce_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_reduce_arbiter_if.sv
// Bus between barrett_reduce_arbiter, its requesters and the shared barrett_reduce instance.
// Handshake: a beat moves on a rising clk edge where the sender's valid and the receiver's ready are both high.
interface barrett_reduce_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*512-1:0] req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [252:0]           rsp_data;
  logic                   rsp_err;
  logic [511:0]           red_in;
  logic                   red_ena;
  logic                   red_ready;
  logic                   red_comp_done;
  logic [252:0]           red_out;
  logic                   mult_busy;

  // Requesters plus the reducer instance.
  modport master (
    output req_valid, req_data, rsp_ready, red_ready, red_comp_done, red_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, red_in, red_ena, mult_busy
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_data, rsp_ready, red_ready, red_comp_done, red_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, red_in, red_ena, mult_busy
  );
endinterface

// File: rtl/barrett_reduce_arbiter.sv
// Round-robin front end that shares one barrett_reduce instance between NUM_REQ requesters,
// sequencing its level-enable/done protocol and aborting hung reductions with an error response.
module barrett_reduce_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  barrett_reduce_arbiter_if.slave bus,
  output logic [1:0]              dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    RUN      = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic [511:0]         op_q, op_d;
  logic [252:0]         rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;

  // Rotating priority: the requester after the last winner is searched first.
  always_comb begin : grant_search
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wdog_d       = wdog_q;
    op_d         = op_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_d         = bus.req_data[int'(grant_idx)*512 +: 512];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        // Also entered after an abort, so a still-busy reducer is never re-enabled early.
        if (bus.red_ready) begin
          wdog_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wdog_q != WD_W'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
        if (bus.red_comp_done) begin
          rsp_data_d  = bus.red_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESP;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      wdog_q       <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wdog_q       <= wdog_d;
      op_q         <= op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // op_q only changes at accept, so red_in is stable for the whole of RUN.
  assign bus.red_in    = op_q;
  assign bus.red_ena   = (state_q == RUN);
  assign bus.mult_busy = (state_q == RUN);
  assign bus.req_ready = (state_q == IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_barrett_reduce_arbiter.sv
// Directed bench for barrett_reduce_arbiter with a behavioural reducer that can also hang or strobe on demand.
module tb_barrett_reduce_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam logic [511:0] L = {259'd0, 1'b1, 124'd0, 128'h14def9dea2f79cd65812631a5cf5d3ed};
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_RESP = 2'd3;

  logic         clk, rst;
  logic [1:0]   dbg_state;
  int           checks, errors;
  int           stub_mode;   // 0: reduce after 3 RUN cycles, 1: hang, 2: strobe stub_value on RUN cycle done_at
  int           done_at;
  int           run_cnt;
  logic [252:0] stub_value;
  logic         stub_stray_done;

  barrett_reduce_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  barrett_reduce_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reducer model, updated on the falling edge so the DUT samples settled values.
  always @(negedge clk) begin : reducer_model
    logic fire;
    if (bus.red_ena) run_cnt = run_cnt + 1;
    else run_cnt = 0;
    fire = 1'b0;
    if (stub_mode == 0) fire = bus.red_ena && (run_cnt == 3);
    else if (stub_mode == 2) fire = bus.red_ena && (run_cnt == done_at);
    bus.red_comp_done = fire || stub_stray_done;
    bus.red_out = (stub_mode == 0) ? 253'(bus.red_in % L) : stub_value;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [511:0] data);
    bus.req_data[idx*512 +: 512] = data;
    bus.req_valid = bus.req_valid | NUM_REQ'(1 << idx);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (dbg_state == s) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_red_ena(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.red_ena) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if (bus.red_ena !== 1'b0 || bus.mult_busy !== 1'b0) begin errors++; $display("FAIL reset_ena_busy got %b%b want 00", bus.red_ena, bus.mult_busy); end
    checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%b want 0000/0", bus.rsp_valid, bus.rsp_err); end
    checks++; if (bus.rsp_data !== 253'd0 || bus.red_in !== 512'd0) begin errors++; $display("FAIL reset_data got %0h/%0h want 0/0", bus.rsp_data, bus.red_in); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if (dbg_state !== S_IDLE || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req got %0d/%b want 0/0000", dbg_state, bus.req_ready); end
  endtask

  task automatic test_single();
    int cnt;
    bit stable;
    bit ok;
    bus.rsp_ready = 4'b0001;
    bus.red_ready = 1'b1;
    stub_mode = 0;
    set_req(0, L + 512'd5);
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got %b want 0001", bus.req_ready); end
    tick();
    checks++; if (dbg_state !== S_WAIT || bus.red_ena !== 1'b0) begin errors++; $display("FAIL single_wait got %0d/%b want 1/0", dbg_state, bus.red_ena); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_outside_idle got %b want 0000", bus.req_ready); end
    bus.req_valid = '0;
    tick();
    checks++; if (bus.red_ena !== 1'b1 || bus.mult_busy !== 1'b1) begin errors++; $display("FAIL single_run_ena got %b%b want 11", bus.red_ena, bus.mult_busy); end
    checks++; if (bus.red_in !== L + 512'd5) begin errors++; $display("FAIL single_red_in got %0h want %0h", bus.red_in, L + 512'd5); end
    cnt = 1;
    stable = 1'b1;
    while (bus.red_ena && cnt < 100) begin
      tick();
      if (bus.red_ena) begin
        cnt++;
        if (bus.red_in !== L + 512'd5) stable = 1'b0;
      end
    end
    checks++; if (cnt != 3) begin errors++; $display("FAIL single_run_cycles got %0d want 3", cnt); end
    checks++; if (!stable) begin errors++; $display("FAIL single_red_in_stable got 0 want 1"); end
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got %b want 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 253'd5 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp got %0h/%b want 5/0", bus.rsp_data, bus.rsp_err); end
    tick();
    wait_state(S_IDLE, ok);
    checks++; if (!ok || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_back_idle got %0d/%b want 0/0000", dbg_state, bus.rsp_valid); end
  endtask

  task automatic test_operands();
    logic [511:0] ops [3];
    logic [252:0] exps [3];
    logic [511:0] all1;
    bit ok;
    all1 = '1;
    ops[0] = 512'd0;  exps[0] = 253'd0;
    ops[1] = all1;    exps[1] = 253'(all1 % L);
    ops[2] = L - 512'd1; exps[2] = 253'(L - 512'd1);
    bus.rsp_ready = 4'b1111;
    stub_mode = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(i, ops[i]);
      tick();
      bus.req_valid = '0;
      wait_state(S_RESP, ok);
      checks++; if (!ok || bus.rsp_valid !== NUM_REQ'(1 << i)) begin errors++; $display("FAIL operand%0d_owner got %b want %b", i, bus.rsp_valid, NUM_REQ'(1 << i)); end
      checks++; if (bus.rsp_data !== exps[i] || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL operand%0d_data got %0h/%b want %0h/0", i, bus.rsp_data, bus.rsp_err, exps[i]); end
      tick();
    end
  endtask

  task automatic record_grants(input logic [3:0] valid_mask, input int n, output int got [6]);
    int k;
    int cyc;
    bit ok;
    k = 0;
    cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*512 +: 512] = L + 512'(i + 1);
    bus.req_valid = valid_mask;
    #1;
    while (k < n && cyc < 500) begin
      if (bus.req_ready != 4'b0000) begin
        checks++; if ($countones(bus.req_ready) != 1 || (bus.req_ready & ~valid_mask) != 4'b0000) begin errors++; $display("FAIL rr_onehot got %b want one of %b", bus.req_ready, valid_mask); end
        for (int b = 0; b < NUM_REQ; b++) if (bus.req_ready[b]) got[k] = b;
        k++;
      end
      tick();
      cyc++;
    end
    bus.req_valid = '0;
    checks++; if (k != n) begin errors++; $display("FAIL rr_grant_count got %0d want %0d", k, n); end
    wait_state(S_IDLE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain got %0d want 0", dbg_state); end
  endtask

  task automatic test_round_robin();
    int got [6];
    int exp_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_b [3] = '{1, 3, 1};
    bus.rsp_ready = 4'b1111;
    stub_mode = 0;
    apply_reset();
    got = '{default: -1};
    record_grants(4'b1111, 6, got);
    for (int i = 0; i < 6; i++) begin
      checks++; if (got[i] != exp_a[i]) begin errors++; $display("FAIL rr_all_grant%0d got %0d want %0d", i, got[i], exp_a[i]); end
    end
    apply_reset();
    got = '{default: -1};
    record_grants(4'b1010, 3, got);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] != exp_b[i]) begin errors++; $display("FAIL rr_sparse_grant%0d got %0d want %0d", i, got[i], exp_b[i]); end
    end
  endtask

  task automatic test_watchdog();
    int cnt;
    bit ok;
    stub_mode = 1;
    bus.red_ready = 1'b1;
    bus.rsp_ready = 4'b0000;
    set_req(1, L + 512'd9);
    tick();
    bus.req_valid = '0;
    wait_red_ena(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wdog_run_start got 0 want 1"); end
    cnt = 0;
    while (bus.red_ena && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++; if (cnt != TIMEOUT) begin errors++; $display("FAIL wdog_run_cycles got %0d want %0d", cnt, TIMEOUT); end
    checks++; if (bus.rsp_valid !== 4'b0010 || dbg_state !== S_RESP) begin errors++; $display("FAIL wdog_rsp_valid got %b/%0d want 0010/3", bus.rsp_valid, dbg_state); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 253'd0) begin errors++; $display("FAIL wdog_err got %b/%0h want 1/0", bus.rsp_err, bus.rsp_data); end
  endtask

  task automatic test_recovery_backpressure();
    bit ok;
    bus.red_ready = 1'b0;
    bus.rsp_ready = 4'b0010;
    tick();
    checks++; if (dbg_state !== S_IDLE || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL recov_idle got %0d/%b want 0/0000", dbg_state, bus.rsp_valid); end
    bus.rsp_ready = 4'b0001;
    stub_mode = 0;
    set_req(2, L + 512'd7);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.red_ena !== 1'b0 || dbg_state !== S_WAIT) begin errors++; $display("FAIL recov_hold%0d got %b/%0d want 0/1", i, bus.red_ena, dbg_state); end
      tick();
    end
    bus.red_ready = 1'b1;
    tick();
    checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL recov_run got %0d want 2", dbg_state); end
    wait_state(S_RESP, ok);
    checks++; if (!ok || bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 253'd7 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL recov_rsp got %b/%0h/%b want 0100/7/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    set_req(0, L + 512'd11);
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_data, bus.req_ready, dbg_state} !== {4'b0100, 253'd7, 4'b0000, S_RESP}) begin errors++; $display("FAIL bp_hold%0d got %b/%0h/%b/%0d want 0100/7/0000/3", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, dbg_state); end
      tick();
    end
    bus.rsp_ready = 4'b0101;
    tick();
    checks++; if (dbg_state !== S_IDLE || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_release got %0d/%b want 0/0000", dbg_state, bus.rsp_valid); end
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    wait_state(S_RESP, ok);
    checks++; if (!ok || bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 253'd11) begin errors++; $display("FAIL bp_next_rsp got %b/%0h want 0001/b", bus.rsp_valid, bus.rsp_data); end
    tick();
  endtask

  task automatic test_same_cycle();
    int cnt;
    bit ok;
    stub_mode = 2;
    done_at = TIMEOUT;
    stub_value = 253'h1_2345_6789_abcd;
    bus.rsp_ready = 4'b1111;
    set_req(3, L + 512'd1);
    tick();
    bus.req_valid = '0;
    wait_red_ena(ok);
    cnt = 0;
    while (bus.red_ena && cnt < 100) begin
      cnt++;
      tick();
    end
    checks++; if (!ok || cnt != TIMEOUT) begin errors++; $display("FAIL tie_run_cycles got %0d want %0d", cnt, TIMEOUT); end
    checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_data !== 253'h1_2345_6789_abcd || bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL tie_done_wins got %b/%0h/%b want 0/123456789abcd/1000", bus.rsp_err, bus.rsp_data, bus.rsp_valid); end
    tick();
  endtask

  task automatic test_stray_done();
    bit ok;
    stub_mode = 2;
    done_at = 0;
    stub_value = 253'hdead;
    stub_stray_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({dbg_state, bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {S_IDLE, 4'b0000, 1'b0, 253'h1_2345_6789_abcd}) begin errors++; $display("FAIL stray_idle got %0d/%b/%b/%0h want 0/0000/0/123456789abcd", dbg_state, bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    stub_stray_done = 1'b0;
    bus.red_ready = 1'b0;
    tick();
    set_req(0, L + 512'd3);
    tick();
    bus.req_valid = '0;
    stub_stray_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if ({dbg_state, bus.rsp_valid, bus.red_ena, bus.rsp_data} !== {S_WAIT, 4'b0000, 1'b0, 253'h1_2345_6789_abcd}) begin errors++; $display("FAIL stray_wait got %0d/%b/%b/%0h want 1/0000/0/123456789abcd", dbg_state, bus.rsp_valid, bus.red_ena, bus.rsp_data); end
    stub_stray_done = 1'b0;
    tick();
    done_at = 2;
    stub_value = 253'h77;
    bus.red_ready = 1'b1;
    wait_state(S_RESP, ok);
    checks++; if (!ok || bus.rsp_data !== 253'h77 || bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL stray_then_run got %0h/%b want 77/0001", bus.rsp_data, bus.rsp_valid); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    stub_mode = 1;
    bus.red_ready = 1'b1;
    set_req(2, L + 512'd4);
    tick();
    bus.req_valid = '0;
    wait_red_ena(ok);
    tick();
    tick();
    checks++; if (!ok || bus.red_ena !== 1'b1) begin errors++; $display("FAIL midrun_in_run got %b want 1", bus.red_ena); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.red_ena !== 1'b0 || bus.mult_busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrun_async_drop got %b%b/%b want 00/0000", bus.red_ena, bus.mult_busy, bus.rsp_valid); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL midrun_state got %0d want 0", dbg_state); end
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midrun_first_grant got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    run_cnt = 0;
    stub_mode = 0;
    done_at = 0;
    stub_value = '0;
    stub_stray_done = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.rsp_ready = '0;
    bus.red_ready = 1'b0;
    bus.red_comp_done = 1'b0;
    bus.red_out = '0;
    test_reset();
    test_single();
    test_operands();
    test_round_robin();
    test_watchdog();
    test_recovery_backpressure();
    test_same_cycle();
    test_stray_done();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
